// File: rtl/vedic16x16_seq_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | vedic_pkg : shared widths, FSM states and step limit for Vedic blocks    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package vedic_pkg;
    localparam int OP_W  = 16;
    localparam int RES_W = 32;

    localparam logic [1:0] STEP_LAST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

`default_nettype wire

// File: rtl/vedic16x16_seq_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | vedic16x16_seq_ctrl_if : operand/result valid-ready bus of the sequencer |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface vedic16x16_seq_ctrl_if;
    import vedic_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  a;
    logic [OP_W-1:0]  b;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] result;
    logic             busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

`default_nettype wire

// File: rtl/vedic8x8.sv
// +--------------------------------------------------------------------------+
// | vedic8x8 : combinational 8x8 unsigned multiplier, 4-bit Vedic split      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module vedic8x8 (
    input  wire logic [7:0]  i_a,
    input  wire logic [7:0]  i_b,
    output logic      [15:0] o_p
);
    logic [7:0] w_ll;
    logic [7:0] w_hl;
    logic [7:0] w_lh;
    logic [7:0] w_hh;

    // Vertical (ll, hh) and crosswise (hl, lh) nibble products
    assign w_ll = {4'h0, i_a[3:0]} * {4'h0, i_b[3:0]};
    assign w_hl = {4'h0, i_a[7:4]} * {4'h0, i_b[3:0]};
    assign w_lh = {4'h0, i_a[3:0]} * {4'h0, i_b[7:4]};
    assign w_hh = {4'h0, i_a[7:4]} * {4'h0, i_b[7:4]};

    assign o_p = {8'h00, w_ll}
               + {4'h0, w_hl, 4'h0}
               + {4'h0, w_lh, 4'h0}
               + {w_hh, 8'h00};
endmodule

`default_nettype wire

// File: rtl/vedic16x16_seq_ctrl.sv
// +--------------------------------------------------------------------------+
// | vedic16x16_seq_ctrl : 16x16 multiply over four passes of one vedic8x8    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module vedic16x16_seq_ctrl
    import vedic_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst_n,
    vedic16x16_seq_ctrl_if.slave  bus
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_step;
    logic [OP_W-1:0]  r_a;
    logic [OP_W-1:0]  r_b;
    logic [RES_W-1:0] r_acc;
    logic [RES_W-1:0] r_result;

    logic [7:0]       w_core_a;
    logic [7:0]       w_core_b;
    logic [15:0]      w_pp;
    logic [RES_W-1:0] w_pp_sh;
    logic [RES_W-1:0] w_sum;
    logic             w_in_ready;
    logic             w_accept;

    // Partial product select and alignment for the current step
    always_comb begin
        w_core_a = r_a[7:0];
        w_core_b = r_b[7:0];
        w_pp_sh  = '0;
        case (r_step)
            2'd0: begin
                w_core_a = r_a[7:0];
                w_core_b = r_b[7:0];
                w_pp_sh  = {16'h0000, w_pp};
            end
            2'd1: begin
                w_core_a = r_a[15:8];
                w_core_b = r_b[7:0];
                w_pp_sh  = {8'h00, w_pp, 8'h00};
            end
            2'd2: begin
                w_core_a = r_a[7:0];
                w_core_b = r_b[15:8];
                w_pp_sh  = {8'h00, w_pp, 8'h00};
            end
            default: begin
                w_core_a = r_a[15:8];
                w_core_b = r_b[15:8];
                w_pp_sh  = {w_pp, 16'h0000};
            end
        endcase
    end

    vedic8x8 u_core (
        .i_a (w_core_a),
        .i_b (w_core_b),
        .o_p (w_pp)
    );

    assign w_sum = r_acc + w_pp_sh;

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = ST_MUL;
                end
            end
            ST_MUL: begin
                if (r_step == STEP_LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // DONE->MUL bypass skips the IDLE cycle when a new pair waits
                if (bus.out_ready) begin
                    w_in_ready  = 1'b1;
                    w_state_nxt = bus.in_valid ? ST_MUL : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_accept = w_in_ready & bus.in_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_step   <= 2'd0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a    <= bus.a;
                r_b    <= bus.b;
                r_acc  <= '0;
                r_step <= 2'd0;
            end else if (r_state == ST_MUL) begin
                r_acc  <= w_sum;
                r_step <= r_step + 2'd1;
                if (r_step == STEP_LAST) begin
                    r_result <= w_sum;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready & rst_n;
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.busy      = (r_state == ST_MUL);
    assign bus.result    = r_result;
endmodule

`default_nettype wire

// File: tb/tb_vedic16x16_seq_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_vedic16x16_seq_ctrl : directed table, corner sequences, random pairs  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_vedic16x16_seq_ctrl;
    localparam int NRAND = 2000;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    vedic16x16_seq_ctrl_if bus ();

    vedic16x16_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", nm, act, exp);
    endtask

    task automatic fail_timeout(input string nm);
        n_chk++;
        $display("FAIL %s: timed out, event not seen", nm);
    endtask

    // Entered and left on a negedge; out_ready stays high throughout
    task automatic do_mul(input string nm, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic [31:0] exp);
        int n;
        int busy_cnt;
        bus.a = ta; bus.b = tb_; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (!bus.in_ready) begin
            fail_timeout({nm, "_accept"});
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0; busy_cnt = 0;
        while (!bus.out_valid && n < 12) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk); n++;
        end
        if (!bus.out_valid) begin
            fail_timeout({nm, "_out_valid"});
            return;
        end
        chk({nm, "_latency"}, n, 4);
        chk({nm, "_busy_cycles"}, busy_cnt, 4);
        chk({nm, "_result"}, bus.result, exp);
    endtask

    initial begin
        logic [15:0] bb_a [3];
        logic [15:0] bb_b [3];
        logic [31:0] bb_e [3];
        logic [31:0] q [$];
        logic [31:0] e;
        int k_in, k_out, last_t, n, cnt, n_sent, n_recv;
        logic acc;

        n_chk = 0; n_pass = 0;
        vecs[0] = '{16'h1234, 16'h5678, 32'h06260060, "v1234x5678"};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, "vFFFFxFFFF"};
        vecs[2] = '{16'h0003, 16'h0005, 32'h0000000F, "v3x5"};
        vecs[3] = '{16'h00FF, 16'h00FF, 32'h0000FE01, "vFFxFF"};
        vecs[4] = '{16'hFF00, 16'hFF00, 32'hFE010000, "vFF00xFF00"};
        vecs[5] = '{16'h8000, 16'h8000, 32'h40000000, "v8000x8000"};
        vecs[6] = '{16'hFFFF, 16'h0001, 32'h0000FFFF, "vFFFFx1"};
        vecs[7] = '{16'h0100, 16'h0100, 32'h00010000, "v100x100"};
        bb_a = '{16'h0000, 16'h0001, 16'h00FF};
        bb_b = '{16'hFFFF, 16'h0001, 16'h0100};
        bb_e = '{32'h0, 32'h1, 32'h0000FF00};

        // Reset values
        rst_n = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_result", bus.result, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            do_mul(vecs[i].nm, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Back-to-back with in_valid and out_ready held high
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        k_in = 0; k_out = 0; last_t = 0;
        bus.a = bb_a[0]; bus.b = bb_b[0]; bus.in_valid = 1'b1;
        for (int c = 0; c < 40 && k_out < 3; c++) begin
            #1;
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                chk("b2b_result", bus.result, bb_e[k_out]);
                if (k_out > 0) chk("b2b_interval", c - last_t, 5);
                last_t = c;
                k_out++;
            end
            @(negedge clk);
            if (acc) begin
                k_in++;
                if (k_in < 3) begin
                    bus.a = bb_a[k_in]; bus.b = bb_b[k_in];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        if (k_out < 3) fail_timeout("b2b_outputs");
        bus.in_valid = 1'b0;
        @(negedge clk);

        // Backpressure: product held while out_ready is low
        bus.a = 16'h0007; bus.b = 16'h0009; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 12) begin
            @(negedge clk); n++;
        end
        if (!bus.out_valid) fail_timeout("bp_out_valid");
        bus.a = 16'h0002; bus.b = 16'h0003; bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("bp_result", bus.result, 32'h0000003F);
            chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(negedge clk);
        chk("bp_consumed_busy", {31'b0, bus.busy}, 32'd1);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 12) begin
            @(negedge clk); n++;
        end
        if (!bus.out_valid) fail_timeout("bp_second_out_valid");
        chk("bp_second_result", bus.result, 32'h00000006);
        @(negedge clk);

        // Reset asserted at step 2 of a multiply
        bus.a = 16'h1111; bus.b = 16'h2222; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
        chk("midrst_result", bus.result, 32'h0);
        chk("midrst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
        end
        chk("midrst_no_output", cnt, 0);
        do_mul("after_rst_3x5", 16'h0003, 16'h0005, 32'h0000000F);
        bus.in_valid = 1'b0;
        @(negedge clk);

        // Random pairs with random gaps, in-order scoreboard
        n_sent = 0; n_recv = 0;
        for (int c = 0; c < 60000 && n_recv < NRAND; c++) begin
            if (n_sent < NRAND) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.a = 16'($urandom);
                bus.b = 16'($urandom);
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(32'(bus.a) * 32'(bus.b));
                n_sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("rand_unexpected_output", bus.result, 32'hxxxxxxxx);
                end else begin
                    e = q.pop_front();
                    chk("rand_result", bus.result, e);
                end
                n_recv++;
            end
            @(negedge clk);
        end
        chk("rand_count", n_recv, NRAND);
        chk("rand_queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

`default_nettype wire
